// File: rtl/serial_adder_nbit_if.sv
// Handshake and data bundle for serial_adder_nbit.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_nbit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/serial_adder_nbit.sv
// Bit-serial adder, BPC bits per clock, LSB slice first.
// Define SERIAL_ADDER_SUB_EN to add the subtract mode.
module serial_adder_nbit #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input logic              clk,
  input logic              rst_n,
  serial_adder_nbit_if.slave bus
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("serial_adder_nbit: WIDTH out of range");
  end
  if (BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_bpc
    $error("serial_adder_nbit: BPC must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_q;
`endif

  logic [BPC-1:0]   sa;
  logic [BPC-1:0]   sb;
  logic [BPC-1:0]   ss;
  logic [BPC:0]     t;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] acc_n;
  logic             last;

  always_comb begin
    sa = opa[BPC-1:0];
`ifdef SERIAL_ADDER_SUB_EN
    sb = sub_q ? ~opb[BPC-1:0] : opb[BPC-1:0];
`else
    sb = opb[BPC-1:0];
`endif
    t     = {1'b0, sa} + {1'b0, sb} + {{BPC{1'b0}}, cy};
    ss    = t[BPC-1:0];
    c_out = t[BPC];
    // carry into the slice MSB; on the last slice this is the word MSB
    c_msb = sa[BPC-1] ^ sb[BPC-1] ^ ss[BPC-1];
    acc_n = acc >> BPC;
    acc_n[WIDTH-1 -: BPC] = ss;
  end

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= IDLE;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (st)
        IDLE, DONE: begin
          if (bus.start) begin
            st     <= RUN;
            busy_q <= 1'b1;
            opa    <= bus.a;
            opb    <= bus.b;
            acc    <= '0;
            cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q  <= bus.sub;
            cy     <= bus.sub ? ~bus.cin : bus.cin;
`else
            cy     <= bus.cin;
`endif
          end else begin
            st <= IDLE;
          end
        end
        RUN: begin
          opa <= opa >> BPC;
          opb <= opb >> BPC;
          acc <= acc_n;
          cy  <= c_out;
          cnt <= cnt + CW'(1);
          if (last) begin
            st     <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            sum_q  <= acc_n;
            cout_q <= c_out;
            ovf_q  <= c_out ^ c_msb;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: BPC=1, 4 and 8 instances,
// scoreboard queues filled at start, drained on done.
module tb_serial_adder_nbit;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   dn1   = 0;
  int   dn4   = 0;
  int   dn8   = 0;
  int   d;
  logic [9:0] q1[$];
  logic [9:0] q4[$];
  logic [9:0] q8[$];

  always #5 clk = ~clk;

  serial_adder_nbit_if #(.WIDTH(8)) i1 ();
  serial_adder_nbit_if #(.WIDTH(8)) i4 ();
  serial_adder_nbit_if #(.WIDTH(8)) i8 ();

  serial_adder_nbit #(.WIDTH(8), .BPC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1.slave));
  serial_adder_nbit #(.WIDTH(8), .BPC(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(i4.slave));
  serial_adder_nbit #(.WIDTH(8), .BPC(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(i8.slave));

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  function automatic logic [9:0] model(
    logic [7:0] a, logic [7:0] b, logic ci, logic sb);
    logic [7:0] bb;
    logic       c;
    logic [8:0] f;
    logic [7:0] lo;
    bb = sb ? ~b : b;
    c  = sb ? ~ci : ci;
    f  = {1'b0, a} + {1'b0, bb} + 9'(c);
    lo = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + 8'(c);
    return {lo[7] ^ f[8], f[8], f[7:0]};
  endfunction

  function automatic logic [1:0] st(int sel);
    case (sel)
      1:       return {i1.busy, i1.done};
      4:       return {i4.busy, i4.done};
      default: return {i8.busy, i8.done};
    endcase
  endfunction

  function automatic logic [11:0] outs(int sel);
    case (sel)
      1:       return {i1.busy, i1.done, i1.cout, i1.ovf, i1.sum};
      4:       return {i4.busy, i4.done, i4.cout, i4.ovf, i4.sum};
      default: return {i8.busy, i8.done, i8.cout, i8.ovf, i8.sum};
    endcase
  endfunction

  task automatic set_start(int sel, logic v);
    case (sel)
      1:       i1.start = v;
      4:       i4.start = v;
      default: i8.start = v;
    endcase
  endtask

  task automatic start_op(int sel, logic [7:0] a, logic [7:0] b,
                          logic ci, logic sb, bit push);
    logic [9:0] e;
    logic       s;
`ifdef SERIAL_ADDER_SUB_EN
    s = sb;
`else
    s = 1'b0;
`endif
    e = model(a, b, ci, s);
    case (sel)
      1: begin
        i1.start = 1'b1; i1.a = a; i1.b = b; i1.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
        i1.sub = s;
`endif
        if (push) q1.push_back(e);
      end
      4: begin
        i4.start = 1'b1; i4.a = a; i4.b = b; i4.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
        i4.sub = s;
`endif
        if (push) q4.push_back(e);
      end
      default: begin
        i8.start = 1'b1; i8.a = a; i8.b = b; i8.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
        i8.sub = s;
`endif
        if (push) q8.push_back(e);
      end
    endcase
  endtask

  // glitch >= 0 re-asserts start with new operands at that RUN sample
  task automatic wait_op(int sel, int n, int glitch);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (k == glitch + 1) set_start(sel, 1'b0);
      chk($sformatf("busy%0d k%0d", sel, k), 32'(st(sel)), 32'h2);
      if (k == glitch) start_op(sel, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    if (glitch == n - 1) set_start(sel, 1'b0);
    chk($sformatf("done%0d", sel), 32'(st(sel)), 32'h1);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (i1.done === 1'b1) begin
      dn1++;
      chk("q1 nonempty", 32'(q1.size() > 0), 32'h1);
      if (q1.size() > 0)
        chk("res1", 32'({i1.ovf, i1.cout, i1.sum}), 32'(q1.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (i4.done === 1'b1) begin
      dn4++;
      chk("q4 nonempty", 32'(q4.size() > 0), 32'h1);
      if (q4.size() > 0)
        chk("res4", 32'({i4.ovf, i4.cout, i4.sum}), 32'(q4.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (i8.done === 1'b1) begin
      dn8++;
      chk("q8 nonempty", 32'(q8.size() > 0), 32'h1);
      if (q8.size() > 0)
        chk("res8", 32'({i8.ovf, i8.cout, i8.sum}), 32'(q8.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0;
    i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.cin = 1'b0;
    i4.start = 1'b0; i4.a = '0; i4.b = '0; i4.cin = 1'b0;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    i1.sub = 1'b0; i4.sub = 1'b0; i8.sub = 1'b0;
`endif
    idle(2);
    chk("rst1", 32'(outs(1)), 32'h0);
    chk("rst4", 32'(outs(4)), 32'h0);
    chk("rst8", 32'(outs(8)), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // FF+01: carry out, no overflow
    start_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_op(1, 8, -1);
    idle(2);
    chk("hold sum", 32'(outs(1)), 32'h200);
    // 7F+01: signed overflow
    start_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_op(1, 8, -1);
    idle(2);
`ifdef SERIAL_ADDER_SUB_EN
    start_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
    wait_op(1, 8, -1);
    idle(2);
    start_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    wait_op(1, 8, -1);
    idle(2);
    start_op(4, 8'h30, 8'h10, 1'b1, 1'b1, 1'b1);
    wait_op(4, 2, -1);
    idle(2);
`endif

    start_op(4, 8'h3C, 8'h0A, 1'b1, 1'b0, 1'b1);
    wait_op(4, 2, -1);
    idle(2);
    start_op(4, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
    wait_op(4, 2, -1);
    idle(2);

    // N=1: one busy cycle then done
    for (int i = 0; i < 6; i++) begin
      start_op(8, 8'($urandom), 8'($urandom), 1'($urandom),
               1'($urandom), 1'b1);
      wait_op(8, 1, -1);
      idle(1);
    end

    // start during RUN cycle 3 is ignored, one done only
    d = dn1;
    start_op(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    wait_op(1, 8, 2);
    idle(4);
    chk("one done", 32'(dn1), 32'(d + 1));

    // back-to-back: start held in the done cycle
    start_op(1, 8'h10, 8'h20, 1'b1, 1'b0, 1'b1);
    wait_op(1, 8, -1);
    start_op(1, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b1);
    wait_op(1, 8, -1);
    idle(2);

    // reset at RUN cycle 4 discards the operation
    d = dn1;
    start_op(1, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_start(1, 1'b0);
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun rst", 32'(outs(1)), 32'h0);
    idle(10);
    chk("no done rst", 32'(dn1), 32'(d));
    chk("idle rst", 32'(outs(1)), 32'h0);

    // reset wins over start
    rst_n = 1'b0;
    start_op(1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    set_start(1, 1'b0);
    chk("rst+start a", 32'(st(1)), 32'h0);
    @(negedge clk);
    chk("rst+start b", 32'(st(1)), 32'h0);
    idle(10);
    chk("no done rs", 32'(dn1), 32'(d));

    start_op(1, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);
    wait_op(1, 8, -1);
    idle(2);

    chk("q1 drained", 32'(q1.size()), 32'h0);
    chk("q4 drained", 32'(q4.size()), 32'h0);
    chk("q8 drained", 32'(q8.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
